// File: rtl/i2c_controller_if.sv
// Command/status bundle between the codec config sequencer and the I2C write engine.
// Latency: n/a (wires only).
// Backpressure: none; go is a level request and end_o holds until go is released.
interface i2c_controller_if;
  logic        go;        // level request: high starts/holds a transfer, low aborts/clears
  logic [23:0] i2c_data;  // {slave addr incl. R/W, sub-address, data}
  logic        i2c_sclk;  // registered I2C clock
  logic        end_o;     // transfer complete
  logic [2:0]  ack;       // sampled ACK slots, 0 = acknowledged

  // Controller side
  modport master (
    input  go,
    input  i2c_data,
    output i2c_sclk,
    output end_o,
    output ack
  );

  // Sequencer side
  modport slave (
    output go,
    output i2c_data,
    input  i2c_sclk,
    input  end_o,
    input  ack
  );
endinterface

// File: rtl/i2c_controller.sv
// Single-shot I2C master write: START, 3 bytes each with an ACK slot, STOP.
// Latency: 60 clk_i2c edges from the first edge with go high to end_o high; two edges per SCL bit.
// Backpressure: none; go is held by the requester, low aborts at once, end_o holds while go stays high.
module i2c_controller (
  input  logic                clk_i2c,
  input  logic                reset_n,
  i2c_controller_if.master    bus,
  // Open-drain data line, kept as a plain port so it resolves with the board pull-up.
  inout  wire                 i2c_sdat
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  step_q, step_d;     // edge index relative to the latching edge
  logic [23:0] shift_q, shift_d;   // MSB is the next bit to go out
  logic        sclk_q, sclk_d;
  logic        sda_oe_q, sda_oe_d; // 1 = pull SDA low, 0 = release
  logic        end_q, end_d;
  logic [2:0]  ack_q, ack_d;

  logic       sda_in;
  logic [5:0] bit_off;
  logic [4:0] bit_idx;
  logic       bit_phase;
  logic       ack_slot;

  // Never drive a 1 onto the bus; release and let the pull-up do it.
  assign i2c_sdat     = sda_oe_q ? 1'b0 : 1'bz;
  assign sda_in       = i2c_sdat;

  assign bus.i2c_sclk = sclk_q;
  assign bus.end_o    = end_q;
  assign bus.ack      = ack_q;

  // Bit k occupies steps 2+2k (SCL low, new SDA) and 3+2k (SCL high).
  assign bit_off   = step_q - 6'd2;
  assign bit_idx   = bit_off[5:1];
  assign bit_phase = bit_off[0];
  assign ack_slot  = (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);

  // State, step counter, shift register and bus line registers.
  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      step_q   <= 6'd0;
      shift_q  <= 24'd0;
      sclk_q   <= 1'b1;
      sda_oe_q <= 1'b0;
      end_q    <= 1'b1;
      ack_q    <= 3'b000;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      shift_q  <= shift_d;
      sclk_q   <= sclk_d;
      sda_oe_q <= sda_oe_d;
      end_q    <= end_d;
      ack_q    <= ack_d;
    end
  end

  // Next-state: step through START, 27 bit slots, STOP; go low wins over everything.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    shift_d  = shift_q;
    sclk_d   = sclk_q;
    sda_oe_d = sda_oe_q;
    end_d    = end_q;
    ack_d    = ack_q;

    if (!bus.go) begin
      // Abort or idle: lines released, no STOP, ack keeps whatever was sampled.
      state_d  = ST_IDLE;
      step_d   = 6'd0;
      sclk_d   = 1'b1;
      sda_oe_d = 1'b0;
      end_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Latching edge: command is captured here and ignored afterwards.
          shift_d  = bus.i2c_data;
          ack_d    = 3'b000;
          sclk_d   = 1'b1;
          sda_oe_d = 1'b0;
          end_d    = 1'b0;
          step_d   = 6'd1;
          state_d  = ST_RUN;
        end
        ST_RUN: begin
          step_d = step_q + 6'd1;
          if (step_q == 6'd1) begin
            sda_oe_d = 1'b1;                 // START: SDA falls while SCL high
          end else if (step_q <= 6'd55) begin
            if (!bit_phase) begin
              sclk_d = 1'b0;
              if (ack_slot) begin
                sda_oe_d = 1'b0;             // hand the line to the slave
              end else begin
                sda_oe_d = ~shift_q[23];
                shift_d  = {shift_q[22:0], 1'b0};
              end
            end else begin
              sclk_d = 1'b1;
            end
          end else if (step_q == 6'd56) begin
            sclk_d   = 1'b0;
            sda_oe_d = 1'b1;                 // hold SDA low ahead of STOP
          end else if (step_q == 6'd57) begin
            sclk_d   = 1'b1;
          end else if (step_q == 6'd58) begin
            sda_oe_d = 1'b0;                 // STOP: SDA rises while SCL high
          end else begin
            end_d   = 1'b1;
            state_d = ST_DONE;
          end

          // ACK level is taken at the edge that ends each ACK slot's high phase.
          if (step_q == 6'd20) ack_d[2] = sda_in;
          if (step_q == 6'd38) ack_d[1] = sda_in;
          if (step_q == 6'd56) ack_d[0] = sda_in;
        end
        ST_DONE: begin
          end_d = 1'b1;                      // one shot: wait here until go drops
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
module tb_i2c_controller;
  logic clk_i2c = 1'b0;
  logic reset_n;
  wire  sda_w;
  logic slave_pull = 1'b0;

  i2c_controller_if bus();

  i2c_controller dut (
    .clk_i2c  (clk_i2c),
    .reset_n  (reset_n),
    .bus      (bus),
    .i2c_sdat (sda_w)
  );

  pullup (sda_w);
  assign sda_w = slave_pull ? 1'b0 : 1'bz;

  always #5 clk_i2c = ~clk_i2c;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural slave: reacts to bus events seen shortly after each clock edge.
  int         fall_n    = 99;
  int         start_cnt = 0;
  logic       p_scl     = 1'b1;
  logic       p_sda     = 1'b1;
  logic       slave_en  = 1'b0;
  logic [2:0] slv_nack  = 3'b000;

  always @(posedge clk_i2c) begin
    #2;
    if (!reset_n || !bus.go) begin
      slave_pull = 1'b0;
      fall_n     = 99;
    end else if (p_scl && bus.i2c_sclk && p_sda && !sda_w) begin
      start_cnt++;
      fall_n = -1;
    end else if (p_scl && !bus.i2c_sclk && fall_n < 27) begin
      fall_n++;
      // Every ninth SCL low phase belongs to the slave for byte fall_n/9.
      slave_pull = slave_en && (fall_n < 27) && (fall_n % 9 == 8) && !slv_nack[2 - fall_n / 9];
    end
    p_scl = bus.i2c_sclk;
    p_sda = sda_w;
  end

  // A byte reads back acknowledged only when a slave is present and accepts it.
  function automatic logic [2:0] model_ack(input logic sen, input logic [2:0] nack);
    return sen ? nack : 3'b111;
  endfunction

  typedef struct {
    logic [23:0] data;
    logic        sen;
    logic [2:0]  nack;
    logic [2:0]  exp_ack;
    logic        chg;
  } vec_t;

  task automatic run_xfer(input logic [23:0] data, input logic sen, input logic [2:0] nack,
                          input logic [2:0] exp_ack, input logic chg);
    logic        scl_s[60];
    logic        sda_s[60];
    logic        end_s[60];
    logic [23:0] word = '0;
    int          bad = 0;
    int          first_end = -1;
    slave_en = sen;
    slv_nack = nack;
    @(negedge clk_i2c);
    bus.go       = 1'b1;
    bus.i2c_data = data;
    for (int e = 0; e < 60; e++) begin
      @(negedge clk_i2c);
      scl_s[e] = bus.i2c_sclk;
      sda_s[e] = sda_w;
      end_s[e] = bus.end_o;
      if (chg && e == 0) bus.i2c_data = ~data;
    end
    chk("start", {28'd0, scl_s[0], sda_s[0], scl_s[1], sda_s[1]}, 32'hE);
    for (int k = 0; k < 27; k++) begin
      if (scl_s[2+2*k] !== 1'b0 || scl_s[3+2*k] !== 1'b1) bad++;
      if (k % 9 != 8) begin
        if (sda_s[2+2*k] !== sda_s[3+2*k]) bad++;
        word = {word[22:0], sda_s[3+2*k]};
      end
    end
    chk("bit_timing", bad, 0);
    chk("serial_word", {8'd0, word}, {8'd0, data});
    chk("stop", {26'd0, scl_s[56], sda_s[56], scl_s[57], sda_s[57], scl_s[58], sda_s[58]}, 32'b001011);
    for (int e = 0; e < 60; e++) if (end_s[e] === 1'b1 && first_end < 0) first_end = e;
    chk("end_latency", first_end, 59);
    chk("ack", {29'd0, bus.ack}, {29'd0, exp_ack});
  endtask

  task automatic drop_go();
    bus.go = 1'b0;
    @(negedge clk_i2c);
    chk("drop_end", {31'd0, bus.end_o}, 0);
    chk("drop_idle", {30'd0, bus.i2c_sclk, sda_w}, 32'b11);
  endtask

  task automatic abort_xfer(input logic [2:0] nack, input int ab, input logic [2:0] exp_ack);
    slave_en = 1'b1;
    slv_nack = nack;
    @(negedge clk_i2c);
    bus.go       = 1'b1;
    bus.i2c_data = 24'h341E00;
    for (int e = 0; e < ab; e++) @(negedge clk_i2c);
    bus.go = 1'b0;
    @(negedge clk_i2c);
    chk("abort_lines", {30'd0, bus.i2c_sclk, sda_w}, 32'b11);
    chk("abort_end", {31'd0, bus.end_o}, 0);
    chk("abort_ack", {29'd0, bus.ack}, {29'd0, exp_ack});
  endtask

  initial begin
    vec_t        vecs[4];
    logic [23:0] d;
    logic        s;
    logic [2:0]  n;
    int          bad;

    vecs[0] = '{24'h341E00, 1'b1, 3'b000, 3'b000, 1'b0};
    vecs[1] = '{24'h341E00, 1'b0, 3'b000, 3'b111, 1'b0};
    vecs[2] = '{24'h340479, 1'b1, 3'b001, 3'b001, 1'b1};
    vecs[3] = '{24'hA5C33C, 1'b1, 3'b010, 3'b010, 1'b0};

    // Reset values
    reset_n      = 1'b0;
    bus.go       = 1'b0;
    bus.i2c_data = 24'd0;
    repeat (3) @(negedge clk_i2c);
    chk("reset_sclk", {31'd0, bus.i2c_sclk}, 1);
    chk("reset_sda",  {31'd0, sda_w}, 1);
    chk("reset_end",  {31'd0, bus.end_o}, 1);
    chk("reset_ack",  {29'd0, bus.ack}, 0);
    reset_n = 1'b1;
    @(negedge clk_i2c);
    chk("idle_end", {31'd0, bus.end_o}, 0);

    // Directed vectors; the first one also holds go long after completion.
    for (int i = 0; i < 4; i++) begin
      if (i == 0) start_cnt = 0;
      run_xfer(vecs[i].data, vecs[i].sen, vecs[i].nack, vecs[i].exp_ack, vecs[i].chg);
      if (i == 0) begin
        bad = 0;
        for (int c = 0; c < 100; c++) begin
          @(negedge clk_i2c);
          if (bus.end_o !== 1'b1 || bus.i2c_sclk !== 1'b1 || sda_w !== 1'b1) bad++;
        end
        chk("hold_idle", bad, 0);
        chk("start_count", start_cnt, 1);
        chk("hold_ack", {29'd0, bus.ack}, {29'd0, vecs[0].exp_ack});
      end
      drop_go();
    end

    // Random transfers against the reference ack model
    for (int r = 0; r < 4; r++) begin
      d = 24'($urandom);
      s = ($urandom_range(0, 3) != 0);
      n = 3'($urandom_range(0, 7));
      run_xfer(d, s, n, model_ack(s, n), 1'b0);
      drop_go();
    end

    // Abort before the first ACK sample, then after it (partial ack kept)
    abort_xfer(3'b000, 20, 3'b000);
    abort_xfer(3'b100, 22, 3'b100);

    // Reset mid-transfer
    slave_en = 1'b1;
    slv_nack = 3'b100;
    @(negedge clk_i2c);
    bus.go       = 1'b1;
    bus.i2c_data = 24'h5A5A5A;
    repeat (30) @(negedge clk_i2c);
    chk("pre_reset_ack", {29'd0, bus.ack}, 32'b100);
    @(posedge clk_i2c);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_reset_sclk", {31'd0, bus.i2c_sclk}, 1);
    chk("mid_reset_sda",  {31'd0, sda_w}, 1);
    chk("mid_reset_end",  {31'd0, bus.end_o}, 1);
    chk("mid_reset_ack",  {29'd0, bus.ack}, 0);
    @(negedge clk_i2c);
    bus.go  = 1'b0;
    reset_n = 1'b1;
    @(negedge clk_i2c);
    chk("post_reset_end", {31'd0, bus.end_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
